// File: rtl/free_list_pkg.sv
// Free-list sizing, pointer/tag types and packed request/response packets shared by the rename stage.
// Pointers carry one extra MSB wrap bit, so full and empty are distinguishable without a counter.
package free_list_pkg;
  localparam int NUM_PR   = 64;
  localparam int NUM_ARCH = 32;
  localparam int NUM_FL   = NUM_PR - NUM_ARCH;
  localparam int NUM_ROB  = 8;

  localparam int PR_W     = $clog2(NUM_PR);
  localparam int ROB_W    = $clog2(NUM_ROB);
  localparam int FL_IDX_W = $clog2(NUM_FL);
  localparam int FL_PTR_W = FL_IDX_W + 1;

  typedef logic [PR_W-1:0]     T_t;
  typedef logic [ROB_W-1:0]    ROB_IDX_t;
  typedef logic [FL_IDX_W-1:0] FL_IDX_t;
  typedef logic [FL_PTR_W-1:0] FL_PTR_t;

  typedef struct packed {
    logic     dispatch_en;
    ROB_IDX_t ROB_tail_idx;
    logic     retire_en;
    T_t       Told_idx;
    logic     rollback_en;
    ROB_IDX_t ROB_rollback_idx;
  } FREE_LIST_PACKET_IN;

  typedef struct packed {
    T_t      T_idx;
    logic    empty;
    FL_PTR_t free_count;
  } FREE_LIST_PACKET_OUT;

  localparam FL_PTR_t FL_HEAD_RESET = '0;
  localparam FL_PTR_t FL_TAIL_RESET = FL_PTR_t'(NUM_FL);

  localparam FREE_LIST_PACKET_OUT FREE_LIST_RESET = '{
    T_idx:      T_t'(NUM_ARCH),
    empty:      1'b0,
    free_count: FL_PTR_t'(NUM_FL)
  };

  function automatic T_t fl_reset_tag(input int i);
    return T_t'(NUM_ARCH + i);
  endfunction

  function automatic FL_IDX_t fl_idx(input FL_PTR_t p);
    return p[FL_IDX_W-1:0];
  endfunction
endpackage

// File: rtl/free_list_if.sv
// Rename-stage port bundle for the free list: request packet from dispatch/retire/squash, response with head tag.
interface free_list_if;
  import free_list_pkg::*;

  FREE_LIST_PACKET_IN  req;
  FREE_LIST_PACKET_OUT rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);
endinterface

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of tags plus per-ROB head snapshots for branch rollback.
// Updates land one cycle after the edge; outputs come straight from registers; dispatch must stall on empty.
module free_list
  import free_list_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  free_list_if.slave  fl_bus
);

  T_t      fl          [NUM_FL];
  FL_PTR_t backup_head [NUM_ROB];
  FL_PTR_t head, tail, head_nxt, tail_nxt;
  FL_PTR_t free_count;
  logic    empty, full;
  logic    pop, push, rollback;

  assign free_count = tail - head;
  assign empty      = (free_count == '0);
  assign full       = (free_count == FL_PTR_t'(NUM_FL));

  // A squash overrides dispatch entirely, including its snapshot write.
  assign rollback = en && fl_bus.req.rollback_en;
  assign pop      = en && fl_bus.req.dispatch_en && !empty && !rollback;
  assign push     = en && fl_bus.req.retire_en && !full;

  always_comb begin
    head_nxt = head;
    tail_nxt = tail;
    if (rollback)
      head_nxt = backup_head[fl_bus.req.ROB_rollback_idx];
    else if (pop)
      head_nxt = head + 1'b1;
    if (push)
      tail_nxt = tail + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head <= FL_HEAD_RESET;
      tail <= FL_TAIL_RESET;
      for (int i = 0; i < NUM_FL; i++)
        fl[i] <= fl_reset_tag(i);
      for (int r = 0; r < NUM_ROB; r++)
        backup_head[r] <= '0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      if (pop)
        backup_head[fl_bus.req.ROB_tail_idx] <= head + 1'b1;
      if (push)
        fl[fl_idx(tail)] <= fl_bus.req.Told_idx;
    end
  end

  assign fl_bus.rsp = '{
    T_idx:      fl[fl_idx(head)],
    empty:      empty,
    free_count: free_count
  };

  // Retiring into a full list means a tag was freed twice upstream.
  push_when_full: assert property (@(posedge clock) disable iff (!reset)
                                   !(en && fl_bus.req.retire_en && full));

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset image, in-order pops, empty/refill, rollback, wrap, async reset and stall.
module tb_free_list;
  import free_list_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic en    = 1'b0;
  FREE_LIST_PACKET_IN req;
  int checks       = 0;
  int failures     = 0;
  int illegal_pops = 0;

  free_list_if bus ();
  assign bus.req = req;

  free_list dut (
    .clock  (clock),
    .reset  (reset),
    .en     (en),
    .fl_bus (bus.slave)
  );

  always #5 clock = ~clock;

  // Dispatch is required to stall while empty; count every cycle it does not.
  always @(posedge clock)
    if (reset && en && req.dispatch_en && bus.rsp.empty)
      illegal_pops++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    req = '0;

    // Held in reset
    #12;
    chk("rst_t_idx",  32'(bus.rsp.T_idx), 32);
    chk("rst_count",  32'(bus.rsp.free_count), 32);
    chk("rst_empty",  32'(bus.rsp.empty), 0);
    reset = 1'b1;
    en    = 1'b1;
    cyc();

    // Drain: tags 32..63 in order
    for (int i = 0; i < 32; i++) begin
      req.dispatch_en  = 1'b1;
      req.ROB_tail_idx = ROB_IDX_t'(i);
      chk("pop_seq", 32'(bus.rsp.T_idx), 32'(32 + i));
      cyc();
    end
    chk("drained_empty", 32'(bus.rsp.empty), 1);
    chk("drained_count", 32'(bus.rsp.free_count), 0);

    // Dispatch while empty is ignored and flagged
    cyc();
    req.dispatch_en = 1'b0;
    chk("empty_pop_t_idx", 32'(bus.rsp.T_idx), 32);
    chk("empty_pop_count", 32'(bus.rsp.free_count), 0);
    chk("empty_pop_flag",  32'(illegal_pops), 1);

    // Retire tag 5 into empty list; no same-cycle bypass
    req.retire_en = 1'b1;
    req.Told_idx  = T_t'(5);
    chk("push_same_cycle_empty", 32'(bus.rsp.empty), 1);
    cyc();
    req.retire_en = 1'b0;
    chk("push_next_t_idx", 32'(bus.rsp.T_idx), 5);
    chk("push_next_empty", 32'(bus.rsp.empty), 0);
    chk("push_next_count", 32'(bus.rsp.free_count), 1);

    // Burst of pop+push, then async reset between edges
    req.dispatch_en = 1'b1;
    req.retire_en   = 1'b1;
    req.Told_idx    = T_t'(7);
    cyc();
    chk("burst_t_idx", 32'(bus.rsp.T_idx), 7);
    chk("burst_count", 32'(bus.rsp.free_count), 1);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_t_idx", 32'(bus.rsp.T_idx), 32);
    chk("async_rst_count", 32'(bus.rsp.free_count), 32);
    chk("async_rst_empty", 32'(bus.rsp.empty), 0);
    en = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;

    // Stall: requests present but en low
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_t_idx", 32'(bus.rsp.T_idx), 32);
      chk("stall_count", 32'(bus.rsp.free_count), 32);
    end
    req = '0;
    en  = 1'b1;

    // Three dispatches into ROB slots 0..2
    for (int i = 0; i < 3; i++) begin
      req.dispatch_en  = 1'b1;
      req.ROB_tail_idx = ROB_IDX_t'(i);
      chk("rb_pop", 32'(bus.rsp.T_idx), 32'(32 + i));
      cyc();
    end
    chk("rb_pre_t_idx", 32'(bus.rsp.T_idx), 35);
    chk("rb_pre_count", 32'(bus.rsp.free_count), 29);

    // Rollback to slot 0 with a competing dispatch into slot 0
    req.rollback_en      = 1'b1;
    req.ROB_rollback_idx = ROB_IDX_t'(0);
    req.ROB_tail_idx     = ROB_IDX_t'(0);
    cyc();
    chk("rb_t_idx", 32'(bus.rsp.T_idx), 33);
    chk("rb_count", 32'(bus.rsp.free_count), 31);

    // Second rollback to slot 0 proves the snapshot survived; retire still pushes
    req.dispatch_en = 1'b0;
    req.retire_en   = 1'b1;
    req.Told_idx    = T_t'(9);
    cyc();
    req = '0;
    chk("rb2_t_idx", 32'(bus.rsp.T_idx), 33);
    chk("rb2_count", 32'(bus.rsp.free_count), 32);

    // Walk head to idx 31 and tail to idx 30 (first cycle full, so pop only)
    for (int c = 1; c <= 30; c++) begin
      req.dispatch_en = 1'b1;
      req.retire_en   = (c > 1);
      req.Told_idx    = T_t'(8 + c);
      chk("walk_pop", 32'(bus.rsp.T_idx), 32'(32 + c));
      cyc();
    end
    chk("walk_t_idx", 32'(bus.rsp.T_idx), 63);
    chk("walk_count", 32'(bus.rsp.free_count), 31);

    // Head wraps idx 31 -> 0 with simultaneous push
    req.dispatch_en = 1'b1;
    req.retire_en   = 1'b1;
    req.Told_idx    = T_t'(50);
    cyc();
    chk("head_wrap_t_idx", 32'(bus.rsp.T_idx), 9);
    chk("head_wrap_count", 32'(bus.rsp.free_count), 31);

    // Tail wraps idx 31 -> 0 with simultaneous pop
    req.Told_idx = T_t'(51);
    cyc();
    req = '0;
    chk("tail_wrap_t_idx", 32'(bus.rsp.T_idx), 10);
    chk("tail_wrap_count", 32'(bus.rsp.free_count), 31);
    chk("no_extra_illegal_pops", 32'(illegal_pops), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
